// File: rtl/solver_trace_reader.sv
// Solver trace capture buffer: decimated sample capture into a 2^AW-entry FIFO drained by the processor.
// Optional build macro TRACE_TIMESTAMP_EN stores a 16-bit sample stamp with each entry (rd_stamp output).
module solver_trace_reader #(
  parameter int DW   = 18,
  parameter int AW   = 6,
  parameter int DECW = 8
) (
  input  logic            clk50,
  input  logic            NIOS_reset,
  input  logic            smp_valid,
  input  logic [DW-1:0]   smp_data,
  input  logic            arm,
  input  logic [DECW-1:0] decim,
  input  logic            rd_req,
  output logic [DW-1:0]   rd_data,
  output logic            rd_ack,
  output logic [3:0]      status,
`ifdef TRACE_TIMESTAMP_EN
  output logic [15:0]     rd_stamp,
`endif
  output logic [AW:0]     level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int SW = DW + 16;
`else
  localparam int SW = DW;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   wptr, rptr;
  logic [DECW-1:0] decim_q, dec_cnt;
  logic            overflow;
  logic [SW-1:0]   mem [DEPTH];
  logic [SW-1:0]   entry, rd_word;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]     stamp;
`endif

  logic            full, wr_req, wr_en, pop;
  logic [AW:0]     level_nxt;

  assign full = (level == FULL_LVL);

  // The first sample after arm is always kept; later ones only at decimation phase 0.
  // An arm in the same cycle wins over any write or pop.
  assign wr_req = smp_valid && !arm &&
                  ((state == ARMED) || (state == CAPTURE && dec_cnt == '0));
  assign wr_en  = wr_req && !full;
  assign pop    = rd_req && (level != '0) && !rd_ack && !arm;

`ifdef TRACE_TIMESTAMP_EN
  assign entry = {stamp, smp_data};
`else
  assign entry = smp_data;
`endif
  assign rd_word = mem[rptr];

  // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    level_nxt = level;
    case ({wr_en, pop})
      2'b10:   level_nxt = level + (AW+1)'(1);
      2'b01:   level_nxt = level - (AW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  // NOTE: the sample RAM has no reset; stale contents are unreachable because level gates every pop.
  always_ff @(posedge clk50) begin
    if (wr_en) mem[wptr] <= entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk50 or negedge NIOS_reset) begin
    if (!NIOS_reset) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      decim_q  <= '0;
      dec_cnt  <= '0;
      overflow <= 1'b0;
      rd_ack   <= 1'b0;
      rd_data  <= '0;
`ifdef TRACE_TIMESTAMP_EN
      stamp    <= '0;
      rd_stamp <= '0;
`endif
    end else begin
      rd_ack <= pop;
      if (pop) begin
        rd_data  <= rd_word[DW-1:0];
`ifdef TRACE_TIMESTAMP_EN
        rd_stamp <= rd_word[SW-1:DW];
`endif
      end

      if (arm) begin
        state    <= ARMED;
        wptr     <= '0;
        rptr     <= '0;
        level    <= '0;
        overflow <= 1'b0;
        decim_q  <= decim;
        dec_cnt  <= '0;
`ifdef TRACE_TIMESTAMP_EN
        stamp    <= '0;
`endif
      end else begin
        if (wr_en) wptr <= wptr + AW'(1);
        if (pop)   rptr <= rptr + AW'(1);
        level <= level_nxt;
        // A write that finds the buffer full is dropped, never overwrites.
        if (wr_req && full) overflow <= 1'b1;
`ifdef TRACE_TIMESTAMP_EN
        if (smp_valid) stamp <= stamp + 16'd1;
`endif

        case (state)
          ARMED: begin
            if (smp_valid) begin
              dec_cnt <= (decim_q == '0) ? '0 : DECW'(1);
              state   <= (wr_en && level_nxt == FULL_LVL) ? DONE : CAPTURE;
            end
          end
          CAPTURE: begin
            if (smp_valid) begin
              dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DECW'(1);
              if (wr_en && level_nxt == FULL_LVL) state <= DONE;
            end
          end
          DONE: begin
            if (level == '0) state <= IDLE;
          end
          default: state <= state;
        endcase
      end
    end
  end

  assign status = {(state == ARMED) || (state == CAPTURE), (state == DONE), (level == '0), overflow};

endmodule
